// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared state encodings for the 0101 stream sequencer
package seq_ctrl_pkg;
    typedef enum logic {IDLE, SHIFT} ctrl_t;
    typedef enum logic [2:0] {S0, S1, S2, S3, S4} det_t;
endpackage

// File: rtl/seq_stream_ctrl_if.sv
// seq_stream_ctrl_if: valid/ready word handshake between producer and serialiser
interface seq_stream_ctrl_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    modport master (output data, valid, input ready);
    modport slave (input data, valid, output ready);
endinterface

// File: rtl/seq0101_core.sv
// seq0101_core: overlapping 0101 Moore detector, advances only on bit_vld; hit pulses on entry to the match state
module seq0101_core
    import seq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic bit_vld,
    input  logic bit_in,
    output logic match,
    output logic hit
);
    det_t st, st_nx;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) st <= S0;
        else st <= clr ? S0 : st_nx;
    always_comb begin
        st_nx = st;
        if (bit_vld)
            case (st)
                S0: st_nx = bit_in ? S0 : S1;
                S1: st_nx = bit_in ? S2 : S1;
                S2: st_nx = bit_in ? S0 : S3;
                S3: st_nx = bit_in ? S4 : S1;
                S4: st_nx = bit_in ? S0 : S3;
                default: st_nx = S0;
            endcase
        match = st == S4;
        hit = bit_vld && st_nx == S4;
    end
endmodule

// File: rtl/seq_stream_ctrl.sv
// seq_stream_ctrl: MSB-first word serialiser feeding a 0101 detector, saturating match counter and sticky irq.
// Define MATCH_POS_EN to add last_pos, the stream position of the most recent match.
module seq_stream_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    seq_stream_ctrl_if.slave s,
    input  logic             clr,
    input  logic [CNT_W-1:0] thresh,
    output logic             bit_out,
    output logic             bit_vld,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             irq
`ifdef MATCH_POS_EN
    , output logic [15:0]    last_pos
`endif
);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    ctrl_t st, st_nx;
    logic [DATA_W-1:0] sreg;
    logic [IW-1:0] idx;
    logic last, accept, hit;
    logic [CNT_W-1:0] cnt_nx;
    always_comb begin
        busy = st == SHIFT;
        last = busy && idx == IW'(DATA_W - 1);
        s.ready = !busy || last;
        accept = s.valid && s.ready;
        st_nx = accept ? SHIFT : (last ? IDLE : st);
        bit_vld = busy;
        bit_out = sreg[DATA_W-1];
        cnt_nx = (hit && !(&match_cnt)) ? match_cnt + 1'b1 : match_cnt;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st <= IDLE;
            sreg <= '0;
            idx <= '0;
        end else begin
            st <= st_nx;
            sreg <= accept ? s.data : (busy ? sreg << 1 : sreg);
            idx <= accept ? '0 : (busy ? idx + 1'b1 : idx);
        end
    seq0101_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .bit_vld(bit_vld),
        .bit_in (bit_out),
        .match  (match),
        .hit    (hit)
    );
    // irq only fires on the increment that reaches thresh, so retuning thresh never clears or retriggers it
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            match_cnt <= '0;
            irq <= 1'b0;
        end else if (clr) begin
            match_cnt <= '0;
            irq <= 1'b0;
        end else begin
            match_cnt <= cnt_nx;
            if (hit && thresh != '0 && cnt_nx == thresh) irq <= 1'b1;
        end
`ifdef MATCH_POS_EN
    logic [15:0] pos;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pos <= '0;
            last_pos <= '0;
        end else begin
            if (bit_vld) pos <= pos + 16'd1;
            if (clr) last_pos <= '0;
            else if (hit) last_pos <= pos;
        end
`endif
endmodule

// File: tb/tb_seq_stream_ctrl.sv
// tb_seq_stream_ctrl: scoreboard bench; expected bits queued at acceptance, monitor replays the 0101 rules per bit
module tb_seq_stream_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic [7:0] thresh = 8'd0;
    logic bit_out, bit_vld, match, busy, irq;
    logic [7:0] match_cnt;
`ifdef MATCH_POS_EN
    logic [15:0] last_pos;
`endif
    seq_stream_ctrl_if #(.DATA_W(8)) s();
    seq_stream_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (s),
        .clr      (clr),
        .thresh   (thresh),
        .bit_out  (bit_out),
        .bit_vld  (bit_vld),
        .match    (match),
        .match_cnt(match_cnt),
        .busy     (busy),
        .irq      (irq)
`ifdef MATCH_POS_EN
        , .last_pos(last_pos)
`endif
    );
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endfunction

    bit q[$];
    logic [3:0] hist;
    int nb, cnt_m, cur_run, last_run;
    logic irq_m, match_m;
    logic [15:0] pos_m, lpos_m;

    function automatic void model_reset();
        hist = 4'd0; nb = 0; cnt_m = 0; irq_m = 1'b0; match_m = 1'b0;
        pos_m = 16'd0; lpos_m = 16'd0; cur_run = 0;
    endfunction

    always @(negedge clk) begin : monitor
        bit b;
        logic hitm;
        logic [15:0] p;
        if (!rst_n) begin
            chk("rst_match", match, 0);
            chk("rst_cnt", match_cnt, 0);
            chk("rst_irq", irq, 0);
            chk("rst_busy", busy, 0);
            chk("rst_bit_vld", bit_vld, 0);
            chk("rst_bit_out", bit_out, 0);
            chk("rst_in_ready", s.ready, 1);
            q.delete();
            model_reset();
        end else begin
            chk("match", match, match_m);
            chk("match_cnt", match_cnt, cnt_m);
            chk("irq", irq, irq_m);
`ifdef MATCH_POS_EN
            chk("last_pos", last_pos, lpos_m);
`endif
            chk("bit_vld", bit_vld, q.size() != 0);
            chk("busy", busy, q.size() != 0);
            chk("in_ready", s.ready, q.size() <= 1);
            if (bit_vld) cur_run++;
            else if (cur_run != 0) begin
                last_run = cur_run;
                cur_run = 0;
            end
            hitm = 1'b0;
            p = pos_m;
            if (q.size() != 0) begin
                b = q.pop_front();
                chk("bit_out", bit_out, b);
                hist = {hist[2:0], b};
                nb++;
                hitm = nb >= 4 && hist == 4'b0101;
                pos_m++;
                match_m = hitm;
            end
            if (clr) begin
                hist = 4'd0; nb = 0; cnt_m = 0; irq_m = 1'b0; match_m = 1'b0; lpos_m = 16'd0;
            end else if (hitm) begin
                if (cnt_m < 255) cnt_m++;
                if (thresh != 0 && cnt_m == int'(thresh)) irq_m = 1'b1;
                lpos_m = p;
            end
        end
    end

    task automatic send(input logic [7:0] w);
        int n = 0;
        s.data = w;
        s.valid = 1'b1;
        while (!s.ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_timeout", n < 100, 1);
        @(posedge clk);
        for (int i = 7; i >= 0; i--) q.push_back(w[i]);
        #1;
        s.valid = 1'b0;
        clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
    endtask

    logic [15:0] pos_start;
    initial begin
        s.data = 8'd0;
        s.valid = 1'b0;
        model_reset();
        last_run = 0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        // 1: threshold irq one cycle after the third match
        thresh = 8'd3;
        send(8'h55);
        idle(7);
        chk("t1_cnt_pre", match_cnt, 2);
        chk("t1_irq_pre", irq, 0);
        idle(1);
        chk("t1_cnt", match_cnt, 3);
        chk("t1_irq", irq, 1);
        chk("t1_match", match, 1);
        idle(3);
        // 2: gapless back-to-back words
        thresh = 8'd0;
        pulse_clr();
        send(8'h05);
        send(8'h50);
        idle(20);
        chk("t2_cnt", match_cnt, 3);
        chk("t2_run", last_run, 16);
        // 3: 0110 path never matches
        pulse_clr();
        send(8'h6D);
        idle(10);
        chk("t3_cnt", match_cnt, 0);
        chk("t3_match", match, 0);
        // 4: clr on the completing edge wins
        thresh = 8'd3;
        pulse_clr();
        send(8'h55);
        idle(7);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("t4_cnt", match_cnt, 0);
        chk("t4_irq", irq, 0);
        chk("t4_match", match, 0);
        idle(3);
        // 5: reset mid-word discards the partial word
        send(8'h55);
        idle(4);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_bit_vld", bit_vld, 0);
        chk("t5_cnt", match_cnt, 0);
        chk("t5_ready", s.ready, 1);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(8'h0A);
        idle(10);
        chk("t5_cnt_after", match_cnt, 1);
        // 6: saturation with irq disabled
        thresh = 8'd0;
        pulse_clr();
        pos_start = pos_m;
        for (int i = 0; i < 80; i++) send(8'h55);
        idle(10);
        chk("t6_cnt", match_cnt, 255);
        chk("t6_irq", irq, 0);
`ifdef MATCH_POS_EN
        chk("t6_last_pos", last_pos, pos_start + 16'd639);
`endif
        // random words, gaps, clears and thresholds
        for (int i = 0; i < 120; i++) begin
            thresh = 8'($urandom_range(0, 12));
            repeat ($urandom_range(0, 3)) begin
                clr = ($urandom_range(0, 9) == 0);
                idle(1);
            end
            clr = ($urandom_range(0, 15) == 0);
            send(8'($urandom));
        end
        idle(12);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
